// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control path: control-FSM state encodings,
// 3-bit opcode constants, instruction width and the default instruction-queue
// depth.
// Contents:
//   state_t          4-bit FSM state encoding (S0 is the idle/issue state)
//   OP_*             opcode field values found in instruction bits [15:13]
//   INSTR_W          instruction word width
//   IQ_DEPTH         default instruction-queue depth
//   is_illegal_op()  true when a word carries the reserved opcode
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W  = 16;
    localparam int IQ_DEPTH = 4;

    typedef enum logic [3:0] {
        S0        = 4'b0000,
        S1        = 4'b0001,
        ST_LOAD   = 4'b0010,
        ST_MOV    = 4'b0011,
        ST_LDPC   = 4'b0100,
        ST_BRANCH = 4'b0101,
        ST_SUB0   = 4'b0110,
        ST_SUB1   = 4'b0111,
        ST_SUB2   = 4'b1000,
        ST_ADD0   = 4'b1001,
        ST_ADD1   = 4'b1010,
        ST_ADD2   = 4'b1011,
        ST_XOR0   = 4'b1100,
        ST_XOR1   = 4'b1101,
        ST_XOR2   = 4'b1110
    } state_t;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_MOV     = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_LDPC    = 3'b101;
    localparam logic [2:0] OP_BRANCH  = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    function automatic logic is_illegal_op(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 3] == OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/instr_queue_if.sv
// -----------------------------------------------------------------------------
// instr_queue_if
// Bundles the instruction-queue signals: the upstream push handshake, the
// control-FSM state/flush inputs and the issue outputs.
// Signals:
//   in_valid  / in_instr / in_ready  upstream push handshake
//   state                            current control-FSM state
//   flush                            discard all queued words
//   instr / new_instr                issued word and issue request
//   count                            number of queued entries
//   illegal                          sticky reserved-opcode flag
// Modports: master (environment side), slave (queue side).
// -----------------------------------------------------------------------------
interface instr_queue_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic [3:0]         state;
    logic               flush;
    logic [INSTR_W-1:0] instr;
    logic               new_instr;
    logic [CNT_W-1:0]   count;
    logic               illegal;

    modport master (
        output in_valid, in_instr, state, flush,
        input  in_ready, instr, new_instr, count, illegal
    );

    modport slave (
        input  in_valid, in_instr, state, flush,
        output in_ready, instr, new_instr, count, illegal
    );

endinterface

// File: rtl/iq_fifo.sv
// -----------------------------------------------------------------------------
// iq_fifo
// Storage for the instruction queue: RAM array, head/tail pointers and the
// entry count. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clock, resetn   clock and asynchronous active-low reset
//   push, wdata     write wdata at the tail (ignored when full or flushing)
//   pop             advance the head (ignored when empty or flushing)
//   flush           empty the queue; overrides push and pop
//   head_data       word at the head of the queue
//   count           queued entries, 0..DEPTH
// -----------------------------------------------------------------------------
module iq_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int DATA_W = INSTR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head_p0;
    logic [PTR_W-1:0]  tail_p0;
    logic [CNT_W-1:0]  count_p0;
    logic              do_push;
    logic              do_pop;

    // Guard against overflow/underflow locally so count stays in 0..DEPTH
    // whatever the caller drives.
    always_comb begin
        do_push = push && !flush && (count_p0 < DEPTH_C);
        do_pop  = pop  && !flush && (count_p0 != '0);
    end

    // Data array carries no reset; only pointers and count are control.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[tail_p0] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head_p0  <= '0;
            tail_p0  <= '0;
            count_p0 <= '0;
        end else if (flush) begin
            head_p0  <= '0;
            tail_p0  <= '0;
            count_p0 <= '0;
        end else begin
            if (do_push) begin
                tail_p0 <= tail_p0 + PTR_W'(1);
            end
            if (do_pop) begin
                head_p0 <= head_p0 + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_p0 <= count_p0 + CNT_W'(1);
                2'b01:   count_p0 <= count_p0 - CNT_W'(1);
                default: count_p0 <= count_p0;
            endcase
        end
    end

    assign head_data = mem[head_p0];
    assign count     = count_p0;

endmodule

// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
// Instruction prefetch queue in front of the control FSM. Words pushed by the
// upstream fetch logic are held in FIFO order and issued one at a time while
// the FSM sits in S0; the issued word is registered and stays stable for the
// whole execution sequence that follows.
// Ports:
//   clock    sole clock, rising edge
//   resetn   asynchronous active-low reset
//   q        instr_queue_if.slave: in_valid/in_instr/in_ready, state, flush,
//            instr, new_instr, count, illegal
// Configuration:
//   IQ_BYPASS_EN  when defined, a word offered to an empty queue while the FSM
//                 is in S0 is issued on the same edge without being queued.
// -----------------------------------------------------------------------------
module instr_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         resetn,
    instr_queue_if.slave q
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               queue_issue;
    logic               bypass;
    logic               fifo_push;
    logic               issue_fire;
    logic [INSTR_W-1:0] issue_word;
    logic [INSTR_W-1:0] instr_p0;
    logic               illegal_p0;

    always_comb begin
        queue_issue = (fifo_count != '0) && (q.state == S0);
`ifdef IQ_BYPASS_EN
        // Empty queue and idle FSM: hand the offered word straight to the
        // issue register instead of spending a cycle in the RAM.
        bypass = (fifo_count == '0) && (q.state == S0) && q.in_valid && !q.flush;
`else
        bypass = 1'b0;
`endif
        fifo_push  = q.in_valid && q.in_ready && !bypass;
        // Flush wins over issue, so the issue register is left untouched.
        issue_fire = (queue_issue || bypass) && !q.flush;
        issue_word = bypass ? q.in_instr : fifo_head;
    end

    iq_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (INSTR_W)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (fifo_push),
        .wdata     (q.in_instr),
        .pop       (queue_issue),
        .flush     (q.flush),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    // Issue register: loads only on an issue so instr holds between issues.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            instr_p0   <= '0;
            illegal_p0 <= 1'b0;
        end else if (issue_fire) begin
            instr_p0 <= issue_word;
            if (is_illegal_op(issue_word)) begin
                illegal_p0 <= 1'b1;
            end
        end
    end

    assign q.in_ready  = (fifo_count < DEPTH_C) && !q.flush;
    assign q.new_instr = queue_issue || bypass;
    assign q.count     = fifo_count;
    assign q.instr     = instr_p0;
    assign q.illegal   = illegal_p0;

endmodule

// File: tb/tb_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_queue
// Directed testbench for instr_queue (DEPTH=4). Works for both builds; the
// issue timing of a push into an empty queue follows IQ_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_instr_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    instr_queue_if #(.DEPTH(DEPTH)) q ();

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .q      (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        q.in_valid = 1'b1;
        q.in_instr = w;
        tick();
        q.in_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        q.in_valid = 1'b0;
        q.in_instr = '0;
        q.state    = S0;
        q.flush    = 1'b0;

        // Reset state
        #12;
        chk("rst_count", 32'(q.count), 32'd0);
        chk("rst_in_ready", 32'(q.in_ready), 32'd1);
        chk("rst_new_instr", 32'(q.new_instr), 32'd0);
        chk("rst_instr", 32'(q.instr), 32'h0);
        chk("rst_illegal", 32'(q.illegal), 32'd0);
        resetn = 1'b1;
        tick();

        // Single push into empty queue, FSM idle
        q.state    = S0;
        q.in_valid = 1'b1;
        q.in_instr = 16'h2000;
        #1;
`ifdef IQ_BYPASS_EN
        chk("byp_new_instr_same_cycle", 32'(q.new_instr), 32'd1);
        tick();
        q.in_valid = 1'b0;
        #1;
        chk("byp_instr", 32'(q.instr), 32'h2000);
        chk("byp_count", 32'(q.count), 32'd0);
        chk("byp_new_instr_after", 32'(q.new_instr), 32'd0);
`else
        chk("lat_new_instr_push_cycle", 32'(q.new_instr), 32'd0);
        tick();
        q.in_valid = 1'b0;
        #1;
        chk("lat_count_queued", 32'(q.count), 32'd1);
        chk("lat_new_instr_next", 32'(q.new_instr), 32'd1);
        tick();
        chk("lat_instr", 32'(q.instr), 32'h2000);
        chk("lat_count_after", 32'(q.count), 32'd0);
        chk("lat_new_instr_after", 32'(q.new_instr), 32'd0);
`endif

        // Fill while FSM busy, reject overflow, then drain in order
        q.state = S1;
        push_word(16'h2001);
        push_word(16'h2002);
        push_word(16'h2003);
        push_word(16'h2004);
        #1;
        chk("full_count", 32'(q.count), 32'd4);
        chk("full_in_ready", 32'(q.in_ready), 32'd0);
        chk("busy_new_instr", 32'(q.new_instr), 32'd0);
        push_word(16'h2005);
        chk("overflow_count", 32'(q.count), 32'd4);
        q.state = S0;
        #1;
        chk("drain_new_instr", 32'(q.new_instr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_instr", 32'(q.instr), 32'h2001 + 32'(i));
            chk("drain_count", 32'(q.count), 32'(3 - i));
        end
        chk("drain_empty_new_instr", 32'(q.new_instr), 32'd0);

        // Push and issue on the same edge
        q.state = S1;
        push_word(16'h3001);
        push_word(16'h3002);
        chk("pi_count_before", 32'(q.count), 32'd2);
        q.state    = S0;
        q.in_valid = 1'b1;
        q.in_instr = 16'h3003;
        #1;
        chk("pi_in_ready", 32'(q.in_ready), 32'd1);
        tick();
        q.in_valid = 1'b0;
        chk("pi_count_same", 32'(q.count), 32'd2);
        chk("pi_instr_oldest", 32'(q.instr), 32'h3001);
        tick();
        chk("pi_instr_2", 32'(q.instr), 32'h3002);
        tick();
        chk("pi_instr_3", 32'(q.instr), 32'h3003);
        chk("pi_count_end", 32'(q.count), 32'd0);

        // Flush with a simultaneous push
        q.state = S1;
        push_word(16'h4001);
        push_word(16'h4002);
        push_word(16'h4003);
        chk("fl_count_before", 32'(q.count), 32'd3);
        q.flush    = 1'b1;
        q.in_valid = 1'b1;
        q.in_instr = 16'h4004;
        #1;
        chk("fl_in_ready", 32'(q.in_ready), 32'd0);
        tick();
        q.flush    = 1'b0;
        q.in_valid = 1'b0;
        chk("fl_count", 32'(q.count), 32'd0);
        chk("fl_instr_kept", 32'(q.instr), 32'h3003);
        q.state = S0;
        #1;
        chk("fl_new_instr", 32'(q.new_instr), 32'd0);
        tick();
        chk("fl_instr_no_issue", 32'(q.instr), 32'h3003);
        chk("fl_illegal_clear", 32'(q.illegal), 32'd0);

        // Sticky illegal opcode flag
        q.state = S1;
        push_word(16'hE123);
        push_word(16'h2222);
        q.state = S0;
        tick();
        chk("ill_instr", 32'(q.instr), 32'hE123);
        chk("ill_set", 32'(q.illegal), 32'd1);
        tick();
        chk("ill_instr_legal", 32'(q.instr), 32'h2222);
        chk("ill_sticky", 32'(q.illegal), 32'd1);

        // Asynchronous reset with words queued
        q.state = S1;
        push_word(16'h5001);
        chk("rst2_count_before", 32'(q.count), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst2_count", 32'(q.count), 32'd0);
        chk("rst2_illegal", 32'(q.illegal), 32'd0);
        chk("rst2_instr", 32'(q.instr), 32'h0);
        chk("rst2_in_ready", 32'(q.in_ready), 32'd1);
        resetn = 1'b1;
        q.state = S0;
        tick();
        chk("rst2_new_instr", 32'(q.new_instr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
